// File: rtl/fp_square_seq.sv
// ---------------------------------------------------------------------------
// fp_square_seq
//
// Sequential IEEE-754 binary32 squaring unit: result = A * A.
// Serves as the check path for the square-root block and as a standalone
// squaring operation.
//
// The operand is captured on the accepting edge. The unit then:
//   1. classifies it,
//   2. runs a 24-step shift-add mantissa multiply,
//   3. normalizes the 48-bit product,
//   4. rounds to nearest even.
//
// Special operands skip the multiplier and finish one cycle after acceptance.
// The sign of a square is always positive, so the operand sign is never stored.
//
// Ports
//   clk     in   1   sole clock, rising edge
//   rst     in   1   synchronous active-high reset
//   start   in   1   request, sampled only while idle
//   A       in  32   operand, needs to be valid only on the accepting edge
//   result  out 32   A squared, held until the next completion
//   done    out  1   registered one-cycle completion pulse
//   busy    out  1   high whenever the unit is not idle
// ---------------------------------------------------------------------------
module fp_square_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   output logic [31:0] result,
   output logic        done,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      MUL,
      NORM,
      ROUND,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   // Operand without its sign bit; squaring always yields a positive value.
   logic [30:0] op_reg;

   // Shift-add multiplier: the multiplicand shifts left and the multiplier
   // shifts right, so bit 0 of the multiplier selects each partial product.
   logic [47:0] mcand;
   logic [23:0] mplier;
   logic [47:0] acc;
   logic [4:0]  count;

   logic signed [9:0] exp_r;
   logic [22:0]       frac;
   logic              guard;
   logic              sticky;

   logic [7:0]        op_exp;
   logic [22:0]       op_frac;
   logic              op_special;
   logic [31:0]       special_result;
   logic signed [9:0] unpack_exp;

   logic              round_up;
   logic [23:0]       frac_sum;
   logic signed [9:0] exp_rnd;
   logic [31:0]       rounded_result;

   logic              unused_sign;

   assign unused_sign = A[31];
   assign busy        = (state != IDLE);

   assign op_exp  = op_reg[30:23];
   assign op_frac = op_reg[22:0];

   // Operand classification and the fixed results of the special cases.
   // NaN inputs give the canonical quiet NaN. Infinity gives +inf.
   // Zeros and denormals (exponent field 0) are flushed to +0.
   always_comb begin
      op_special     = 1'b0;
      special_result = 32'h0000_0000;
      if (op_exp == 8'hFF) begin
         op_special     = 1'b1;
         special_result = (op_frac != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
      end else if (op_exp == 8'h00) begin
         op_special     = 1'b1;
         special_result = 32'h0000_0000;
      end
   end

   // Unbiased exponents add, so the biased result exponent is 2*Ea - 127.
   // It is kept 10-bit signed so that overflow and underflow stay visible
   // until the final range check.
   assign unpack_exp = {1'b0, op_exp, 1'b0} - 10'sd127;

   // Round to nearest, ties to even.
   // A carry out of the 23-bit fraction leaves the fraction at zero and
   // bumps the exponent. The range check is applied after that bump.
   always_comb begin
      round_up = guard & (sticky | frac[0]);
      frac_sum = {1'b0, frac} + {23'd0, round_up};
      exp_rnd  = exp_r + (frac_sum[23] ? 10'sd1 : 10'sd0);
      if (exp_rnd >= 10'sd255) begin
         rounded_result = 32'h7F80_0000;
      end else if (exp_rnd <= 10'sd0) begin
         rounded_result = 32'h0000_0000;
      end else begin
         rounded_result = {1'b0, exp_rnd[7:0], frac_sum[22:0]};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   // MUL performs one partial product per cycle while count runs 0..23.
   // The edge that finds count at 24 (all partial products accumulated)
   // moves on to NORM.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = UNPACK;
         UNPACK:  state_next = op_special ? DONE : MUL;
         MUL:     if (count == 5'd24) state_next = NORM;
         NORM:    state_next = ROUND;
         ROUND:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers.
   // result is written only on the edge that enters DONE, so it stays
   // stable between completions. done is registered from the next state,
   // so it is high exactly for the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_reg <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         exp_r  <= '0;
         frac   <= '0;
         guard  <= 1'b0;
         sticky <= 1'b0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  op_reg <= A[30:0];
               end
            end

            UNPACK: begin
               if (op_special) begin
                  result <= special_result;
               end else begin
                  mcand  <= {24'd0, 1'b1, op_frac};
                  mplier <= {1'b1, op_frac};
                  acc    <= '0;
                  exp_r  <= unpack_exp;
                  count  <= '0;
               end
            end

            MUL: begin
               if (count != 5'd24) begin
                  if (mplier[0]) begin
                     acc <= acc + mcand;
                  end
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 5'd1;
               end
            end

            // The product of two values in [1,2) lies in [1,4).
            // If bit 47 is set the product is at least 2: take the fraction
            // one position higher and bump the exponent.
            NORM: begin
               if (acc[47]) begin
                  frac   <= acc[46:24];
                  guard  <= acc[23];
                  sticky <= |acc[22:0];
                  exp_r  <= exp_r + 10'sd1;
               end else begin
                  frac   <= acc[45:23];
                  guard  <= acc[22];
                  sticky <= |acc[21:0];
               end
            end

            ROUND: begin
               result <= rounded_result;
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_square_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_square_seq
//
// Directed and randomized bench for fp_square_seq.
// Expected squares come from an integer reference model that works on the
// exact 48-bit mantissa product.
// ---------------------------------------------------------------------------
module tb_fp_square_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] A;
   logic [31:0] result;
   logic        done;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   // Observations collected by applyStimulus.
   int          lat_seen;
   int          done_cnt;
   logic [31:0] res_seen;
   logic [31:0] res_end;
   bit          busy_gap;
   bit          busy_after_bad;
   logic [31:0] rst_result;
   logic        rst_busy;
   logic        rst_done;

   fp_square_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .A      (A),
      .result (result),
      .done   (done),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference square computed from the exact integer product of the
   // mantissas.
   // Rounding is round to nearest, ties to even. Results are flushed to
   // zero below the normal range and saturate to infinity above it.
   function automatic logic [31:0] ref_square(input logic [31:0] a);
      int unsigned     ea;
      longint unsigned m;
      longint unsigned p;
      longint unsigned kept;
      longint unsigned rem;
      longint unsigned half;
      int              e;
      int              shift;
      ea = a[30:23];
      if (ea == 255) return (a[22:0] != 23'd0) ? 32'h7FC00000 : 32'h7F800000;
      if (ea == 0) return 32'h00000000;
      m = {40'd0, 1'b1, a[22:0]};
      p = m * m;
      e = 2 * int'(ea) - 127;
      if (p >= (64'd1 << 47)) begin
         shift = 24;
         e = e + 1;
      end else begin
         shift = 23;
      end
      kept = p >> shift;
      rem  = p & ((64'd1 << shift) - 64'd1);
      half = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
      if (kept == (64'd1 << 24)) begin
         kept = kept >> 1;
         e = e + 1;
      end
      if (e >= 255) return 32'h7F800000;
      if (e <= 0) return 32'h00000000;
      return {1'b0, e[7:0], kept[22:0]};
   endfunction

   // Edges from the accepting edge to the edge that enters DONE.
   function automatic int spec_latency(input logic [31:0] a);
      return (a[30:23] == 8'h00 || a[30:23] == 8'hFF) ? 1 : 28;
   endfunction

   task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Issues one operation and watches it for a fixed 40-cycle window.
   // Options:
   //   repulse_at     re-pulses start mid-operation with a different operand
   //   reset_at       asserts rst for one edge
   //   start_in_done  raises start during the DONE cycle
   // Entered and left just after a rising edge.
   task applyStimulus(input logic [31:0] a, input int repulse_at, input int reset_at,
                      input bit start_in_done);
      start = 1'b1;
      A     = a;
      @(posedge clk); #1;
      start = 1'b0;
      A     = $urandom;
      lat_seen       = 0;
      done_cnt       = 0;
      res_seen       = '0;
      busy_gap       = 1'b0;
      busy_after_bad = 1'b0;
      rst_result     = '1;
      rst_busy       = 1'b1;
      rst_done       = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc == repulse_at) begin
            start = 1'b1;
            A     = 32'h40A00000;
         end
         if (cyc == reset_at) rst = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         rst   = 1'b0;
         if (cyc == reset_at) begin
            rst_result = result;
            rst_busy   = busy;
            rst_done   = done;
         end
         if (lat_seen == 0 && reset_at == 0 && !busy) busy_gap = 1'b1;
         if (lat_seen != 0 && cyc <= lat_seen + 2 && busy) busy_after_bad = 1'b1;
         if (done) begin
            done_cnt++;
            if (lat_seen == 0) begin
               lat_seen = cyc;
               res_seen = result;
            end
         end
         if (done && start_in_done) start = 1'b1;
      end
      res_end = result;
   endtask

   task runOp(input string tag, input logic [31:0] a, input logic [31:0] exp_res,
              input int repulse_at, input bit start_in_done);
      applyStimulus(a, repulse_at, 0, start_in_done);
      checkOutput({tag, " result"}, res_seen, exp_res);
      checkOutput({tag, " latency"}, lat_seen, spec_latency(a));
      checkOutput({tag, " done pulses"}, done_cnt, 32'd1);
      checkOutput({tag, " busy during op"}, 32'(busy_gap), 32'd0);
      checkOutput({tag, " busy after done"}, 32'(busy_after_bad), 32'd0);
      checkOutput({tag, " result held"}, res_end, exp_res);
   endtask

   logic [31:0] r;

   initial begin
      // Reset with start held high: the unit must stay idle.
      rst   = 1'b1;
      start = 1'b1;
      A     = 32'h40400000;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset result", result, 32'h0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle busy", 32'(busy), 32'd0);

      // Directed vectors with hand-derived results.
      runOp("3.0", 32'h40400000, 32'h41100000, 0, 1'b0);
      runOp("-1.5", 32'hBFC00000, 32'h40100000, 0, 1'b0);
      runOp("1+ulp", 32'h3F800001, 32'h3F800002, 0, 1'b0);
      // The exact square of this operand is about 2 - 6.9e-8. That is more
      // than half an ulp below 2.0, so it rounds down to the largest float
      // under 2.
      runOp("sqrt2", 32'h3FB504F3, 32'h3FFFFFFF, 0, 1'b0);
      runOp("nan", 32'h7FC00001, 32'h7FC00000, 0, 1'b0);
      runOp("-inf", 32'hFF800000, 32'h7F800000, 0, 1'b0);
      runOp("-zero", 32'h80000000, 32'h00000000, 0, 1'b0);
      runOp("denorm", 32'h00000001, 32'h00000000, 0, 1'b0);
      runOp("overflow", 32'h60AD78EC, 32'h7F800000, 0, 1'b0);
      runOp("underflow", 32'h0DA24260, 32'h00000000, 0, 1'b0);

      // start re-pulsed while busy and again during DONE: both ignored.
      runOp("repulse", 32'h40400000, 32'h41100000, 10, 1'b1);

      // Reset mid-operation: in-flight result discarded, no done pulse.
      applyStimulus(32'h40400000, 0, 15, 1'b0);
      checkOutput("mid-reset result", rst_result, 32'h0);
      checkOutput("mid-reset busy", 32'(rst_busy), 32'd0);
      checkOutput("mid-reset done", 32'(rst_done), 32'd0);
      checkOutput("mid-reset done pulses", done_cnt, 32'd0);
      runOp("after reset", 32'h40400000, 32'h41100000, 0, 1'b0);

      // Randomized operands. Half of them have exponents biased into the
      // normal result range; the rest are unconstrained.
      for (int i = 0; i < 40; i++) begin
         r = $urandom;
         if (i % 2 == 0) r[30:23] = 8'($urandom_range(100, 154));
         runOp("random", r, ref_square(r), 0, (i % 4) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
